// File: rtl/sum_pkg.sv
// Shared constants and digit helper for the BCD accumulator (sum).
// Optional build macro: SUM_SATURATE_EN (saturate instead of wrap on overflow).
package sum_pkg;

    localparam int DIGIT_W     = 4;
    localparam int DIGIT_MAX   = 9;
    localparam int RESULT_W    = 10;
    localparam int RESULT_MAX  = 1023;
    localparam int OPERAND_MAX = 999;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational three-digit BCD to binary converter with digit validation.
module bcd3_to_bin
    import sum_pkg::*;
(
    input  logic [DIGIT_W-1:0]  centenas,
    input  logic [DIGIT_W-1:0]  decenas,
    input  logic [DIGIT_W-1:0]  unidades,
    output logic [RESULT_W-1:0] value,
    output logic                valid
);

    localparam logic [RESULT_W-1:0] WEIGHT_100 = RESULT_W'(100);
    localparam logic [RESULT_W-1:0] WEIGHT_10  = RESULT_W'(10);

    assign valid = digit_ok(centenas) && digit_ok(decenas) && digit_ok(unidades);

    // Value is only meaningful when valid; invalid digits may wrap here harmlessly.
    assign value = RESULT_W'(centenas) * WEIGHT_100
                 + RESULT_W'(decenas)  * WEIGHT_10
                 + RESULT_W'(unidades);

endmodule

// File: rtl/sum.sv
// Edge-triggered BCD accumulator with sticky overflow and invalid-digit pulse.
// Build macro SUM_SATURATE_EN: saturate at RESULT_MAX on overflow; default wraps modulo 1024.
module sum
    import sum_pkg::*;
(
    input  logic                clk,
    input  logic                n_reset,
    input  logic [DIGIT_W-1:0]  centenas,
    input  logic [DIGIT_W-1:0]  decenas,
    input  logic [DIGIT_W-1:0]  unidades,
    input  logic                cargar,
    input  logic                limpiar,
    output logic [RESULT_W-1:0] numero_guardado,
    output logic                desborde,
    output logic                error_bcd
);

    logic [1:0]          rst_sync;
    logic                rst_int_n;
    logic                cargar_q;
    logic                load;
    logic [RESULT_W-1:0] operand;
    logic                operand_valid;
    logic [RESULT_W:0]   sum_full;
    logic                overflow;

    function automatic logic [RESULT_W-1:0] fold_result(input logic [RESULT_W:0] s);
`ifdef SUM_SATURATE_EN
        return s[RESULT_W] ? RESULT_W'(RESULT_MAX) : s[RESULT_W-1:0];
`else
        return s[RESULT_W-1:0];
`endif
    endfunction

    // Assert asynchronously, release two clock edges after n_reset rises.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    bcd3_to_bin u_conv (
        .centenas (centenas),
        .decenas  (decenas),
        .unidades (unidades),
        .value    (operand),
        .valid    (operand_valid)
    );

    assign load     = cargar && !cargar_q;
    assign sum_full = {1'b0, numero_guardado} + {1'b0, operand};
    assign overflow = sum_full[RESULT_W];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cargar_q        <= 1'b0;
            numero_guardado <= '0;
            desborde        <= 1'b0;
            error_bcd       <= 1'b0;
        end else begin
            cargar_q <= cargar;
            if (limpiar) begin
                numero_guardado <= '0;
                desborde        <= 1'b0;
                error_bcd       <= 1'b0;
            end else begin
                error_bcd <= load && !operand_valid;
                if (load && operand_valid) begin
                    numero_guardado <= fold_result(sum_full);
                    if (overflow) desborde <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum.sv
// Randomized and directed self-checking bench for sum against a behavioural model.
module tb_sum;
    import sum_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [3:0]  centenas, decenas, unidades;
    logic        cargar, limpiar;
    logic [9:0]  numero_guardado;
    logic        desborde, error_bcd;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    int m_acc, m_ovf, m_err, m_prev;

    sum dut (
        .clk             (clk),
        .n_reset         (n_reset),
        .centenas        (centenas),
        .decenas         (decenas),
        .unidades        (unidades),
        .cargar          (cargar),
        .limpiar         (limpiar),
        .numero_guardado (numero_guardado),
        .desborde        (desborde),
        .error_bcd       (error_bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_acc = 0; m_ovf = 0; m_err = 0; m_prev = 0;
        end else begin
            int  s;
            bit  ld;
            ld = cargar && !m_prev;
            m_prev = cargar;
            if (limpiar) begin
                m_acc = 0; m_ovf = 0; m_err = 0;
            end else begin
                m_err = 0;
                if (ld) begin
                    if (centenas > 9 || decenas > 9 || unidades > 9) begin
                        m_err = 1;
                    end else begin
                        s = m_acc + centenas * 100 + decenas * 10 + unidades;
                        if (s > 1023) begin
                            m_ovf = 1;
`ifdef SUM_SATURATE_EN
                            m_acc = 1023;
`else
                            m_acc = s % 1024;
`endif
                        end else begin
                            m_acc = s;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_acc", int'(numero_guardado), m_acc);
            check("model_desborde", int'(desborde), m_ovf);
            check("model_error_bcd", int'(error_bcd), m_err);
        end
    end

    task automatic pulse(input int c, input int d, input int u);
        @(negedge clk);
        centenas = 4'(c); decenas = 4'(d); unidades = 4'(u);
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
    endtask

    task automatic clear_acc();
        @(negedge clk);
        limpiar = 1'b1;
        @(negedge clk);
        limpiar = 1'b0;
    endtask

    initial begin
        n_reset = 1'b0;
        centenas = '0; decenas = '0; unidades = '0;
        cargar = 1'b0; limpiar = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_acc", int'(numero_guardado), 0);
        check("reset_desborde", int'(desborde), 0);
        check_en = 1'b1;

        // Two operands
        pulse(1, 5, 6);
        check("two_ops_first", int'(numero_guardado), 156);
        pulse(1, 5, 7);
        check("two_ops_second", int'(numero_guardado), 313);
        check("two_ops_desborde", int'(desborde), 0);

        // Clear has priority over a simultaneous load
        @(negedge clk);
        centenas = 4'd0; decenas = 4'd0; unidades = 4'd7;
        cargar = 1'b1; limpiar = 1'b1;
        @(negedge clk);
        cargar = 1'b0; limpiar = 1'b0;
        check("clear_prio_acc", int'(numero_guardado), 0);
        check("clear_prio_desborde", int'(desborde), 0);

        // Held load adds once
        @(negedge clk);
        centenas = 4'd0; decenas = 4'd0; unidades = 4'd5;
        cargar = 1'b1;
        repeat (3) @(negedge clk);
        cargar = 1'b0;
        check("held_load_acc", int'(numero_guardado), 5);

        // Invalid digit
        clear_acc();
        pulse(0, 4, 0);
        check("invalid_setup", int'(numero_guardado), 40);
        pulse(2, 10, 3);
        check("invalid_acc", int'(numero_guardado), 40);
        check("invalid_err_pulse", int'(error_bcd), 1);
        @(negedge clk);
        check("invalid_err_drop", int'(error_bcd), 0);

        // Overflow
        clear_acc();
        pulse(9, 9, 9);
        check("ovf_first", int'(numero_guardado), 999);
        check("ovf_first_flag", int'(desborde), 0);
        pulse(9, 9, 9);
        check("ovf_flag", int'(desborde), 1);
`ifdef SUM_SATURATE_EN
        check("ovf_acc", int'(numero_guardado), 1023);
`else
        check("ovf_acc", int'(numero_guardado), 974);
`endif
        pulse(0, 0, 1);
        check("ovf_sticky", int'(desborde), 1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 n_reset = 1'b0;
        #1;
        check("async_rst_acc", int'(numero_guardado), 0);
        check("async_rst_desborde", int'(desborde), 0);
        check("async_rst_err", int'(error_bcd), 0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            centenas = 4'($urandom_range(0, 11));
            decenas  = 4'($urandom_range(0, 11));
            unidades = 4'($urandom_range(0, 11));
            cargar   = 1'($urandom_range(0, 1));
            limpiar  = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        cargar = 1'b0; limpiar = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sum.md
SUM -- requirements
Module: sum

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be as follows:
- clk  input  1  rising-edge clock for all state.
- n_reset  input  1  asynchronous active-low reset.
- centenas  input  4  BCD hundreds digit of the operand.
- decenas  input  4  BCD tens digit of the operand.
- unidades  input  4  BCD units digit of the operand.
- cargar  input  1  load request; its rising edge adds the operand.
- limpiar  input  1  synchronous clear of the accumulator and flags.
- numero_guardado  output  10  registered unsigned binary accumulated sum.
- desborde  output  1  sticky flag; set when a sum exceeded 1023.
- error_bcd  output  1  one-cycle pulse when a load is rejected for an invalid digit.

Function
REQ-003 The operand value SHALL be centenas*100 + decenas*10 + unidades, range 0..999, computed combinationally.
REQ-004 A load event SHALL occur at a clk edge where cargar=1 and cargar was 0 at the previous edge.
- cargar is captured in an internal register cargar_q, reset to 0.
REQ-005 Holding cargar high for N cycles SHALL produce exactly one load.
REQ-006 On a load event with all digits 0..9, numero_guardado SHALL become the previous numero_guardado plus the operand, at that same edge.
- Zero added latency; the new value is visible after that edge.
REQ-007 On a load event with any digit above 9:
- numero_guardado SHALL be unchanged;
- error_bcd SHALL be 1 for exactly the following cycle.
- At all other times error_bcd SHALL be 0.
REQ-008 When the 11-bit true sum exceeds 1023:
- desborde SHALL be set to 1;
- desborde SHALL stay 1 until reset or limpiar;
- the accumulator result SHALL follow REQ-013.
REQ-009 limpiar=1 at an edge SHALL set numero_guardado to 0 and clear desborde and error_bcd.
- limpiar has priority over a simultaneous load event.
- The simultaneous load is discarded.
- cargar_q still updates normally.
REQ-010 Inputs SHALL NOT be required to be stable except around the clk edge.
- There is no handshake and no busy state; a new load is accepted every two cycles, the minimum for a rising edge.

Reset
REQ-011 Asserting n_reset=0 SHALL asynchronously force the following to 0:
- numero_guardado;
- desborde;
- error_bcd;
- cargar_q.
REQ-012 Deassertion of n_reset SHALL be synchronised to clk. A reset that arrives in the middle of an operation SHALL discard any pending load.

Configuration
REQ-013 Macro SUM_SATURATE_EN SHALL select the overflow result:
- defined: numero_guardado saturates at 1023;
- undefined: numero_guardado wraps modulo 1024.
- desborde SHALL behave identically in both builds.

Structure
REQ-014 A package sum_pkg SHALL hold the following constants:
- DIGIT_W=4;
- DIGIT_MAX=9;
- RESULT_W=10;
- RESULT_MAX=1023;
- OPERAND_MAX=999.
REQ-015 A combinational sub-module bcd3_to_bin SHALL perform digit validation and the BCD-to-binary conversion.
- Outputs: a 10-bit value and a valid bit.
- sum SHALL instantiate it once.

Verification
REQ-016 The bench SHALL cover the following scenarios:
- Reset: pulse n_reset low mid-cycle -> all outputs 0 immediately, with no clk edge needed.
- Two operands: load 1,5,6 as a one-cycle pulse, then 1,5,7 -> numero_guardado=156, then 313; desborde=0.
- Held load: cargar high 3 cycles with 0,0,5 from 0 -> numero_guardado=5, so exactly one add.
- Invalid digit: load 2,10,3 with accumulator 40 -> numero_guardado stays 40; error_bcd=1 for one cycle.
- Overflow: 999 then 999 -> desborde=1; numero_guardado=1023 with SUM_SATURATE_EN, 974 without it.
- Clear priority: limpiar=1 and a cargar rising edge with 0,0,7 at the same edge, accumulator 313 -> numero_guardado=0 and desborde=0.
